// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the FP CPU boot-time instruction loader.
//   loader_state_t : loader FSM states
//   IMEM_DEPTH     : instruction memory size in bytes
//   IMEM_ADDR_W    : instruction memory byte-address width
//   INSTR_BYTES    : bytes per instruction (program length granule)
package instr_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} loader_state_t;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/instr_mem_loader_fp_if.sv
// Valid/ready program byte stream between the host (UART bridge or bench)
// and the instruction memory loader.
//   byte_valid : stream byte present (host -> loader)
//   byte_data  : stream byte (host -> loader)
//   byte_last  : final byte of the program (host -> loader)
//   byte_ready : loader accepts a byte this cycle (loader -> host)
// Modports: master = host side, slave = loader side.
interface instr_mem_loader_fp_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_valid, byte_data, byte_last, input byte_ready);
  modport slave  (input byte_valid, byte_data, byte_last, output byte_ready);
endinterface

// File: rtl/instr_loader_xor_acc.sv
// 8-bit XOR accumulator used to verify the trailing program checksum.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (takes priority over en)
//   en         : fold din into the accumulator
//   din        : data byte
//   acc        : running XOR of all bytes folded in since the last clear
module instr_loader_xor_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= 8'h00;
    else if (clr) acc <= 8'h00;
    else if (en)  acc <= acc ^ din;
  end
endmodule

// File: rtl/instr_mem_loader_fp.sv
// Boot-time program loader for the FP CPU instruction memory. Writes stream
// bytes to consecutive byte addresses from 0 and holds the CPU in stall until
// a complete, ALIGN-multiple program has loaded.
// Optional macro INSTR_LOADER_CHECKSUM_EN: the byte carrying byte_last is an
// XOR checksum of the preceding data bytes; it is compared, not written.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle pulse that begins a new load
//   host                  : program byte stream (slave side)
//   mem_we/addr/wdata     : registered instruction memory byte write port
//   cpu_stall             : hold the CPU PC and fetch
//   load_done, load_err   : load result flags
//   byte_count            : data bytes written in the current or last load
module instr_mem_loader_fp
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int ALIGN = INSTR_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  instr_mem_loader_fp_if.slave   host,
  output logic                   mem_we,
  output logic [IMEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   cpu_stall,
  output logic                   load_done,
  output logic                   load_err,
  output logic [8:0]             byte_count
);
  loader_state_t state, nxt;

  logic       accept, ovf, data_wr, end_ok, end_bad, restart;
  logic [8:0] cnt_inc;

  assign host.byte_ready = (state == LOAD);
  assign accept  = host.byte_valid && host.byte_ready;
  assign ovf     = (byte_count == 9'(DEPTH));
  assign cnt_inc = byte_count + 9'd1;
  // start is only honoured outside LOAD; it also clears count and checksum
  assign restart = start && (state != LOAD);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       last_ok;

  instr_loader_xor_acc u_xor_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (data_wr),
    .din   (host.byte_data),
    .acc   (acc)
  );

  // Checksum byte is neither written nor counted, so the length check uses
  // the count as it stands; a lone checksum (zero data bytes) is rejected.
  assign last_ok = (byte_count != 9'd0) &&
                   ((byte_count % 9'(ALIGN)) == 9'd0) &&
                   (acc == host.byte_data);
  assign data_wr = accept && !host.byte_last && !ovf;
  assign end_ok  = accept && host.byte_last && last_ok;
  assign end_bad = accept && (host.byte_last ? !last_ok : ovf);
`else
  // Overflow wins over byte_last: a byte past DEPTH is never written.
  assign data_wr = accept && !ovf;
  assign end_ok  = accept && host.byte_last && !ovf &&
                   ((cnt_inc % 9'(ALIGN)) == 9'd0);
  assign end_bad = accept && (ovf || (host.byte_last && !end_ok));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = LOAD;
      LOAD: begin
        if (end_ok)       nxt = DONE;
        else if (end_bad) nxt = ERR;
      end
      default: nxt = IDLE;
    endcase
  end

  // Status flags follow the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stall <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cpu_stall <= (nxt != DONE);
      load_done <= (nxt == DONE);
      load_err  <= (nxt == ERR);
    end
  end

  // data_wr excludes overflow, so the count saturates at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= 9'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
    end else begin
      mem_we <= data_wr;
      if (restart)      byte_count <= 9'd0;
      else if (data_wr) byte_count <= cnt_inc;
      if (data_wr) begin
        mem_addr  <= byte_count[IMEM_ADDR_W-1:0];
        mem_wdata <= host.byte_data;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader_fp.sv
// Directed bench for instr_mem_loader_fp. Stimulus pushes expected memory
// writes into a queue; a monitor pops and compares on every mem_we.
module tb_instr_mem_loader_fp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       cpu_stall, load_done, load_err;
  logic [8:0] byte_count;

  always #5 clk = ~clk;

  instr_mem_loader_fp_if bus ();

  instr_mem_loader_fp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .host       (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h00;
  logic [7:0]  exp_x = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[15:8]));
          chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_addr = 8'h00;
    exp_x    = 8'h00;
    chk("start_ready", 32'(bus.byte_ready), 1);
    chk("start_stall", 32'(cpu_stall), 1);
    chk("start_done",  32'(load_done), 0);
    chk("start_err",   32'(load_err), 0);
    chk("start_count", 32'(byte_count), 0);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic l, input logic wr);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_last  = l;
    chk("byte_ready", 32'(bus.byte_ready), 1);
    if (wr) begin
      exp_q.push_back({exp_addr, d});
      exp_addr++;
    end
    @(posedge clk);
  endtask

  // A program data byte; in checksum builds byte_last moves to a trailing
  // checksum byte computed here.
  task automatic send_data(input logic [7:0] d, input logic l);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_raw(d, 1'b0, 1'b1);
    exp_x ^= d;
    if (l) send_raw(exp_x, 1'b1, 1'b0);
`else
    send_raw(d, l, 1'b1);
`endif
  endtask

  task automatic gap();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    chk("gap_ready", 32'(bus.byte_ready), 1);
    @(posedge clk);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input int cnt);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    chk({tag, "_done"},  32'(load_done), 32'(d));
    chk({tag, "_err"},   32'(load_err), 32'(e));
    chk({tag, "_stall"}, 32'(cpu_stall), 32'(!d));
    chk({tag, "_count"}, 32'(byte_count), 32'(cnt));
    chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stall"}, 32'(cpu_stall), 1);
    chk({tag, "_done"},  32'(load_done), 0);
    chk({tag, "_err"},   32'(load_err), 0);
    chk({tag, "_count"}, 32'(byte_count), 0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
    chk({tag, "_we"},    32'(mem_we), 0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    chk("reset_addr",  32'(mem_addr), 0);
    chk("reset_wdata", 32'(mem_wdata), 0);
    @(negedge clk); rst_n = 1'b1;

    // 8 bytes back to back
    do_start();
    for (int i = 0; i < 8; i++) send_data(8'h10 + 8'(i), i == 7);
    check_end("seq8", 1'b1, 1'b0, 8);

    // same bytes with gaps
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_data(8'h10 + 8'(i), i == 7);
      if (i != 7) gap();
    end
    check_end("gap8", 1'b1, 1'b0, 8);

    // misaligned length
    do_start();
    for (int i = 0; i < 6; i++) send_data(8'hA0 + 8'(i), i == 5);
    check_end("mis6", 1'b0, 1'b1, 6);

    // overflow: 257th byte dropped
    do_start();
    for (int i = 0; i < 256; i++) send_data(8'(i), 1'b0);
    send_raw(8'hAA, 1'b0, 1'b0);
    check_end("ovf", 1'b0, 1'b1, 256);

    // reset mid-load, then a fresh load
    do_start();
    for (int i = 0; i < 3; i++) send_data(8'h55 + 8'(i), 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk); rst_n = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) send_data(8'hC0 + 8'(i), i == 3);
    check_end("postrst", 1'b1, 1'b0, 4);

    // reload from DONE
    do_start();
    send_data(8'h01, 1'b0);
    send_data(8'h02, 1'b0);
    send_data(8'h04, 1'b0);
    send_data(8'h08, 1'b1);
    check_end("reload", 1'b1, 1'b0, 4);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_start();
    send_raw(8'h01, 1'b0, 1'b1);
    send_raw(8'h02, 1'b0, 1'b1);
    send_raw(8'h04, 1'b0, 1'b1);
    send_raw(8'h08, 1'b0, 1'b1);
    send_raw(8'h0F, 1'b1, 1'b0);
    check_end("csum_ok", 1'b1, 1'b0, 4);

    do_start();
    send_raw(8'h01, 1'b0, 1'b1);
    send_raw(8'h02, 1'b0, 1'b1);
    send_raw(8'h04, 1'b0, 1'b1);
    send_raw(8'h08, 1'b0, 1'b1);
    send_raw(8'h0E, 1'b1, 1'b0);
    check_end("csum_bad", 1'b0, 1'b1, 4);

    do_start();
    send_raw(8'h00, 1'b1, 1'b0);
    check_end("csum_empty", 1'b0, 1'b1, 0);
`endif

    repeat (3) @(posedge clk);
    #1 chk("writes_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
